div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin arbiter and sequencer that shares one `div32` sequential divider among `NREQ` requesters. It accepts operand pairs from requesters and issues a single-cycle `div_start` to the divider. It then waits for `div_done` and returns quotient/remainder tagged with the requester index. Divide-by-zero requests are answered directly without occupying the divider. It sits between the requesting units and the shared `div32` instance at the top level.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: bit i = requester i has an operation pending; held high until granted.
- `req_src1` in 32*NREQ: dividend for requester i, at bits [32i+31:32i]; must be stable while `req_valid[i]` is high.
- `req_src2` in 32*NREQ: divisor for requester i, same packing.
- `req_ready` out NREQ: one-hot grant pulse; operands of requester i are captured on this cycle.
- `resp_valid` out 1: one-cycle result pulse; no backpressure.
- `resp_id` out 3: index of the requester owning the result.
- `resp_qut` out 32: quotient.
- `resp_rmd` out 32: remainder.
- `resp_dz` out 1: result was produced by the divide-by-zero path.
- `busy` out 1: high in every state except IDLE.
- `div_start` out 1: single-cycle start pulse to `div32`.
- `div_src1` out 32: dividend to `div32`.
- `div_src2` out 32: divisor to `div32`.
- `div_qut` in 32: quotient from `div32`.
- `div_rmd` in 32: remainder from `div32`.
- `div_done` in 1: result-valid from `div32`.

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE, arbitration:
  - Combinational round-robin search over `req_valid`, starting at pointer `ptr`. The first set bit g wins.
  - `req_ready[g]`=1 that cycle.
  - At the clock edge, the arbiter latches `src1_r`, `src2_r` and `id_r`=g, and updates `ptr`=(g+1) mod NREQ.
- IDLE, next state:
  - If the latched src2 != 0, go to ISSUE.
  - If the latched src2 == 0, go to RESP with the zero-divide result.
  - If no request is pending, stay in IDLE.
- ISSUE: `div_start`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle in which `div_done` is ignored, to mask a stale `done` left from the previous operation. Then go to WAIT.
- WAIT:
  - Hold until `div_done`=1.
  - On that cycle, latch `div_qut`/`div_rmd` into the response registers with dz=0, then go to RESP.
- RESP: `resp_valid`=1 for one cycle with the registered `resp_id`/`resp_qut`/`resp_rmd`/`resp_dz`. Next state is IDLE.
- Zero-divide result: `resp_qut`=32'hFFFF_FFFF, `resp_rmd`=src1, `resp_dz`=1. No `div_start` is issued.
- Divider operands: `div_src1`/`div_src2` are driven from `src1_r`/`src2_r` and held stable from ISSUE through WAIT.
- Grants only in IDLE: at most one operation is outstanding. `req_ready` is 0 in every state except IDLE.
- `div_done` outside WAIT is ignored.
- Response outputs are valid only while `resp_valid`=1. They hold their last value otherwise.

## Timing
- Reset values:
  - State IDLE, `ptr`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_qut`=0, `resp_rmd`=0, `resp_dz`=0, `busy`=0.
  - `div_start`=0, `div_src1`=0, `div_src2`=0.
- Latency, grant in cycle G, normal path:
  - `div_start` in G+1.
  - The earliest accepted `div_done` is in G+3.
  - `resp_valid` is one cycle after the accepted `div_done`.
- Latency, zero-divide path: `resp_valid` in G+1.
- The next grant is possible at the earliest one cycle after RESP. Minimum spacing between normal-path grants is 5 cycles.
- Simultaneous requests are resolved strictly by `ptr`. A requester that is continuously valid waits at most NREQ-1 other operations.
- A requester that drops `req_valid` before being granted is never granted; there is no retained state.
- Reset mid-operation:
  - Return to IDLE with `ptr`=0 on the next edge, with no `resp_valid`.
  - A late `div_done` from the abandoned operation lands in IDLE and is ignored.
  - The next operation's SETTLE masks any residual `done`.

## Test plan
- Bench wiring: `div32` driven with `n_rst` = ~`rst`.
- Single request: requester 1 sends 100/7 → one `req_ready[1]` pulse, one `div_start` pulse, then `resp_valid` with `resp_id`=1, `resp_qut`=14, `resp_rmd`=2, `resp_dz`=0.
- Zero divide: requester 0 sends 0x1234/0 → `resp_valid` at G+1 with `resp_qut`=0xFFFFFFFF, `resp_rmd`=0x1234, `resp_dz`=1, and `div_start` never asserted.
- Round robin: all four requesters held valid with distinct operands (e.g. 31/3, 20/4, 17/5, 9/2) → grant order 0,1,2,3,0. Each response matches its id with results (10,1), (5,0), (3,2), (4,1).
- Pointer fairness: only `req_valid[2]` set → grant 2. Then `req_valid[0]` and `req_valid[3]` set together → grant 3 before 0.
- Stale done: `div_done` held high from the previous op at issue time → the result is taken only from the new `div_done` assertion and is correct for the new operands.
- Reset in WAIT: assert `rst` for one cycle mid-divide → `busy`=0 and all outputs 0 next cycle, no `resp_valid` for the aborted op. A subsequent 50/6 returns 8/2 from requester 0.

Source files
------------

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester, response and divider-side signals of the div_arbiter.
// Latency: none, wiring only.
// Backpressure: req_valid/req_ready handshake on the request side; responses are unthrottled pulses.
interface div_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_src1;
  logic [32*NREQ-1:0]   req_src2;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic [2:0]           resp_id;
  logic [31:0]          resp_qut;
  logic [31:0]          resp_rmd;
  logic                 resp_dz;
  logic                 busy;
  logic                 div_start;
  logic [31:0]          div_src1;
  logic [31:0]          div_src2;
  logic [31:0]          div_qut;
  logic [31:0]          div_rmd;
  logic                 div_done;

  // Arbiter side: owns grants, responses and the divider command.
  modport master (
    input  req_valid, req_src1, req_src2, div_qut, div_rmd, div_done,
    output req_ready, resp_valid, resp_id, resp_qut, resp_rmd, resp_dz, busy,
           div_start, div_src1, div_src2
  );

  // Environment side: requesters plus the shared divider.
  modport slave (
    output req_valid, req_src1, req_src2, div_qut, div_rmd, div_done,
    input  req_ready, resp_valid, resp_id, resp_qut, resp_rmd, resp_dz, busy,
           div_start, div_src1, div_src2
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one div32 among NREQ requesters (divide-by-zero answered locally).
// Latency: div_start 1 cycle after grant, response 1 cycle after accepted div_done; zero-divide response 1 cycle after grant.
// Backpressure: one operation outstanding, grants only in IDLE; responses are one-cycle pulses with no backpressure.
module div_arbiter #(
  parameter int NREQ = 4
) (
  input logic           clk,
  input logic           rst,
  div_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  id_q, id_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [2:0]  resp_id_q, resp_id_d;
  logic [31:0] resp_qut_q, resp_qut_d;
  logic [31:0] resp_rmd_q, resp_rmd_d;
  logic        resp_dz_q, resp_dz_d;

  logic [7:0]  valid_ext;
  logic        gnt_found;
  logic [2:0]  gnt_idx;
  logic [31:0] gnt_src1, gnt_src2;
  logic        grant;

  // Requester index k positions after the pointer, wrapping at NREQ.
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[2:0];
  endfunction

  // Widen to 8 so the 3-bit rotated index always selects in range.
  assign valid_ext = 8'(bus.req_valid);

  // Round-robin search: first pending requester at or after ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && valid_ext[rr_idx(ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(ptr_q, k);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    gnt_src1 = 32'd0;
    gnt_src2 = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        gnt_src1 = bus.req_src1[32*i +: 32];
        gnt_src2 = bus.req_src2[32*i +: 32];
      end
    end
  end

  // Grant only in IDLE; suppressed during reset so a requester never drops a request that reset discards.
  assign grant = gnt_found && (state_q == IDLE) && !rst;

  // One-hot ready pulse towards the winner.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = grant && (gnt_idx == 3'(i));
    end
  end

  // Sequencer next state: capture on grant, issue, mask stale done, wait, respond.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    resp_id_d  = resp_id_q;
    resp_qut_d = resp_qut_q;
    resp_rmd_d = resp_rmd_q;
    resp_dz_d  = resp_dz_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ptr_d  = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
          id_d   = gnt_idx;
          src1_d = gnt_src1;
          src2_d = gnt_src2;
          if (gnt_src2 == 32'd0) begin
            // Divide-by-zero never touches the divider.
            resp_id_d  = gnt_idx;
            resp_qut_d = 32'hFFFF_FFFF;
            resp_rmd_d = gnt_src1;
            resp_dz_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE:  state_d = SETTLE;
      // div_done may still be high from the previous operation here.
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (bus.div_done) begin
          resp_id_d  = id_q;
          resp_qut_d = bus.div_qut;
          resp_rmd_d = bus.div_rmd;
          resp_dz_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      id_q       <= 3'd0;
      src1_q     <= 32'd0;
      src2_q     <= 32'd0;
      resp_id_q  <= 3'd0;
      resp_qut_q <= 32'd0;
      resp_rmd_q <= 32'd0;
      resp_dz_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      resp_id_q  <= resp_id_d;
      resp_qut_q <= resp_qut_d;
      resp_rmd_q <= resp_rmd_d;
      resp_dz_q  <= resp_dz_d;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_qut   = resp_qut_q;
  assign bus.resp_rmd   = resp_rmd_q;
  assign bus.resp_dz    = resp_dz_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.div_start  = (state_q == ISSUE);
  assign bus.div_src1   = src1_q;
  assign bus.div_src2   = src2_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a small behavioural divider.
// Latency: divider result appears a programmable number of cycles after div_start.
// Backpressure: requesters hold req_valid until their grant; responses are recorded as they occur.
module tb_div_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_arbiter_if #(.NREQ(NREQ)) bus ();
  div_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Divider model: done is sticky until the next start; in stale mode it lingers one extra cycle.
  int          m_lat   = 1;
  bit          m_stale = 1'b0;
  logic [31:0] m_a, m_b;
  int          m_cnt;
  logic        m_clr;
  always @(posedge clk) begin
    if (rst) begin
      bus.div_done <= 1'b0;
      bus.div_qut  <= 32'd0;
      bus.div_rmd  <= 32'd0;
      m_cnt        <= 0;
      m_clr        <= 1'b0;
      m_a          <= 32'd0;
      m_b          <= 32'd0;
    end else begin
      m_clr <= 1'b0;
      if (m_clr) bus.div_done <= 1'b0;
      if (bus.div_start) begin
        m_a   <= bus.div_src1;
        m_b   <= bus.div_src2;
        m_cnt <= m_lat;
        if (m_stale) m_clr <= 1'b1;
        else         bus.div_done <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          bus.div_done <= 1'b1;
          bus.div_qut  <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
          bus.div_rmd  <= (m_b == 0) ? m_a : m_a % m_b;
        end
      end
    end
  end

  // Monitor on the falling edge: grants, starts and responses with cycle stamps.
  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } resp_t;
  resp_t           resp_q[$];
  resp_t           mon_r;
  int              gnt_id_q[$];
  int              gnt_cyc_q[$];
  int              start_cyc_q[$];
  logic [31:0]     start_a_q[$];
  logic [31:0]     start_b_q[$];
  logic [NREQ-1:0] last_ready = '0;
  int              cyc = 0;
  int              ready_bad = 0;
  always @(negedge clk) begin
    cyc++;
    last_ready = bus.req_ready;
    if (!rst) begin
      if ($countones(bus.req_ready) > 1) ready_bad++;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i]) begin
          gnt_id_q.push_back(i);
          gnt_cyc_q.push_back(cyc);
        end
      end
      if (bus.div_start) begin
        start_cyc_q.push_back(cyc);
        start_a_q.push_back(bus.div_src1);
        start_b_q.push_back(bus.div_src2);
      end
      if (bus.resp_valid) begin
        mon_r.id  = int'(bus.resp_id);
        mon_r.q   = bus.resp_qut;
        mon_r.r   = bus.resp_rmd;
        mon_r.dz  = bus.resp_dz;
        mon_r.cyc = cyc;
        resp_q.push_back(mon_r);
      end
    end
  end

  // One cycle; requesters granted in the previous cycle withdraw.
  task automatic step();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~last_ready;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_src1[32*i +: 32] = a;
    bus.req_src2[32*i +: 32] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_resp(input int n, input int budget, input string tag);
    int k = 0;
    while (resp_q.size() < n && k < budget) begin
      step();
      k++;
    end
    step();
    step();
    check({tag, "_resp_cnt"}, 32'(resp_q.size()), 32'(n));
  endtask

  task automatic check_resp(input int k, input int id, input logic [31:0] q, input logic [31:0] r,
                            input logic dz, input string tag);
    if (k < resp_q.size()) begin
      check({tag, "_id"},  32'(resp_q[k].id), 32'(id));
      check({tag, "_qut"}, resp_q[k].q, q);
      check({tag, "_rmd"}, resp_q[k].r, r);
      check({tag, "_dz"},  32'(resp_q[k].dz), 32'(dz));
    end else begin
      check({tag, "_present"}, 32'(resp_q.size()), 32'(k + 1));
    end
  endtask

  task automatic check_gnt(input int k, input int id, input string tag);
    if (k < gnt_id_q.size()) check(tag, 32'(gnt_id_q[k]), 32'(id));
    else                     check({tag, "_present"}, 32'(gnt_id_q.size()), 32'(k + 1));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},     32'(bus.busy), 32'd0);
    check({tag, "_ready"},    32'(bus.req_ready), 32'd0);
    check({tag, "_rvalid"},   32'(bus.resp_valid), 32'd0);
    check({tag, "_rid"},      32'(bus.resp_id), 32'd0);
    check({tag, "_rqut"},     bus.resp_qut, 32'd0);
    check({tag, "_rrmd"},     bus.resp_rmd, 32'd0);
    check({tag, "_rdz"},      32'(bus.resp_dz), 32'd0);
    check({tag, "_start"},    32'(bus.div_start), 32'd0);
    check({tag, "_dsrc1"},    bus.div_src1, 32'd0);
    check({tag, "_dsrc2"},    bus.div_src2, 32'd0);
  endtask

  int rb, gb, sb, nr, k;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // Round robin from ptr=0, requester 0 re-requests after its first grant; minimum-latency divider.
    m_lat = 1;
    set_req(0, 31, 3);
    set_req(1, 20, 4);
    set_req(2, 17, 5);
    set_req(3, 9, 2);
    k = 0;
    while (gnt_id_q.size() < 1 && k < 50) begin
      step();
      k++;
    end
    set_req(0, 31, 3);
    wait_resp(5, 200, "rr");
    check_gnt(0, 0, "rr_g0");
    check_gnt(1, 1, "rr_g1");
    check_gnt(2, 2, "rr_g2");
    check_gnt(3, 3, "rr_g3");
    check_gnt(4, 0, "rr_g4");
    check_resp(0, 0, 10, 1, 1'b0, "rr_r0");
    check_resp(1, 1, 5, 0, 1'b0, "rr_r1");
    check_resp(2, 2, 3, 2, 1'b0, "rr_r2");
    check_resp(3, 3, 4, 1, 1'b0, "rr_r3");
    check_resp(4, 0, 10, 1, 1'b0, "rr_r4");
    if (gnt_cyc_q.size() >= 2 && resp_q.size() >= 1) begin
      check("rr_min_spacing", 32'(gnt_cyc_q[1] - gnt_cyc_q[0]), 32'd5);
      check("rr_min_lat", 32'(resp_q[0].cyc - gnt_cyc_q[0]), 32'd4);
    end

    // Pointer fairness: 2 alone, then 0 and 3 together -> 3 before 0.
    m_lat = 2;
    gb = gnt_id_q.size();
    rb = resp_q.size();
    set_req(2, 77, 10);
    wait_resp(rb + 1, 100, "pf1");
    check_gnt(gb, 2, "pf_g2");
    check_resp(rb, 2, 7, 7, 1'b0, "pf_r2");
    set_req(0, 5, 9);
    set_req(3, 1000, 33);
    wait_resp(rb + 3, 100, "pf2");
    check_gnt(gb + 1, 3, "pf_g3");
    check_gnt(gb + 2, 0, "pf_g0");
    check_resp(rb + 1, 3, 30, 10, 1'b0, "pf_r3");
    check_resp(rb + 2, 0, 0, 5, 1'b0, "pf_r0");

    // Single request 100/7 from requester 1, divider latency 3.
    m_lat = 3;
    gb = gnt_id_q.size();
    rb = resp_q.size();
    sb = start_cyc_q.size();
    set_req(1, 100, 7);
    wait_resp(rb + 1, 100, "one");
    check_gnt(gb, 1, "one_g");
    check("one_gnt_cnt", 32'(gnt_id_q.size()), 32'(gb + 1));
    check("one_start_cnt", 32'(start_cyc_q.size()), 32'(sb + 1));
    check_resp(rb, 1, 14, 2, 1'b0, "one_r");
    if (start_cyc_q.size() > sb && gnt_cyc_q.size() > gb && resp_q.size() > rb) begin
      check("one_start_lat", 32'(start_cyc_q[sb] - gnt_cyc_q[gb]), 32'd1);
      check("one_src1", start_a_q[sb], 32'd100);
      check("one_src2", start_b_q[sb], 32'd7);
      check("one_resp_lat", 32'(resp_q[rb].cyc - gnt_cyc_q[gb]), 32'd6);
    end

    // Zero divide from requester 0: answered at G+1, no divider start.
    gb = gnt_id_q.size();
    rb = resp_q.size();
    sb = start_cyc_q.size();
    set_req(0, 32'h1234, 0);
    wait_resp(rb + 1, 50, "dz");
    repeat (4) step();
    check("dz_no_start", 32'(start_cyc_q.size()), 32'(sb));
    check_gnt(gb, 0, "dz_g");
    check_resp(rb, 0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "dz_r");
    if (gnt_cyc_q.size() > gb && resp_q.size() > rb)
      check("dz_lat", 32'(resp_q[rb].cyc - gnt_cyc_q[gb]), 32'd1);

    // Stale done: previous done still high through ISSUE and SETTLE.
    m_stale = 1'b1;
    m_lat   = 3;
    gb = gnt_id_q.size();
    rb = resp_q.size();
    set_req(3, 200, 9);
    wait_resp(rb + 1, 100, "stale");
    check_resp(rb, 3, 22, 2, 1'b0, "stale_r");
    if (gnt_cyc_q.size() > gb && resp_q.size() > rb)
      check("stale_lat", 32'(resp_q[rb].cyc - gnt_cyc_q[gb]), 32'd6);
    m_stale = 1'b0;

    // Reset while waiting on a long divide.
    m_lat = 20;
    sb = start_cyc_q.size();
    set_req(2, 1, 1);
    k = 0;
    while (start_cyc_q.size() <= sb && k < 50) begin
      step();
      k++;
    end
    check("rst_started", 32'(start_cyc_q.size()), 32'(sb + 1));
    repeat (3) step();
    check("rst_in_wait_busy", 32'(bus.busy), 32'd1);
    nr = resp_q.size();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_mid");
    repeat (25) step();
    check("rst_no_resp", 32'(resp_q.size()), 32'(nr));

    // After reset ptr is 0: requesters 0 and 3 together -> 0 first.
    m_lat = 2;
    gb = gnt_id_q.size();
    set_req(0, 50, 6);
    set_req(3, 13, 4);
    wait_resp(nr + 2, 100, "post");
    check_gnt(gb, 0, "post_g0");
    check_gnt(gb + 1, 3, "post_g3");
    check_resp(nr, 0, 8, 2, 1'b0, "post_r0");
    check_resp(nr + 1, 3, 3, 1, 1'b0, "post_r3");

    check("ready_onehot", 32'(ready_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
